// File: rtl/data_mem_loader_if.sv
// Loader-side bus bundle: UART byte stream and CPU store port in; data memory write port and status out.
interface data_mem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cpu_we;
  logic [31:0] cpu_a;
  logic [31:0] cpu_wd;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic        overflow;

  modport slave (
    input  rx_data, rx_valid, cpu_we, cpu_a, cpu_wd,
    output mem_we, mem_a, mem_wd, busy, done, overflow
  );

  modport master (
    output rx_data, rx_valid, cpu_we, cpu_a, cpu_wd,
    input  mem_we, mem_a, mem_wd, busy, done, overflow
  );
endinterface

// File: rtl/data_mem_loader.sv
// Boot loader: big-endian word assembly from UART bytes into data memory, then
// hands the memory write port to the CPU once the image is complete.
module data_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned DEPTH     = 50001
) (
  input logic         clk,
  input logic         rst,
  data_mem_loader_if.slave bus
);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_LAST, S_DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
  } mem_req_t;

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [23:0] sh;
  logic [31:0] cnt;
  logic [31:0] k;
  mem_req_t    lw;
  logic        busy_q, done_q, ovf_q;

  logic        in_rx;
  logic        byte_last;
  logic [31:0] word;

  // Bytes only count while a header or data word is being assembled.
  assign in_rx     = bus.rx_valid && (state == S_HDR || state == S_DATA);
  assign byte_last = in_rx && (idx == 2'd3);
  assign word      = {sh, bus.rx_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HDR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR:   if (byte_last) state_nxt = (word == 32'd0) ? S_DONE : S_DATA;
      S_DATA:  if (byte_last && (k == cnt - 32'd1)) state_nxt = S_LAST;
      S_LAST:  state_nxt = S_DONE;
      default: state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      sh     <= '0;
      cnt    <= '0;
      k      <= '0;
      lw     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      lw.we <= 1'b0;
      if (in_rx) begin
        idx <= idx + 2'd1;
        sh  <= word[23:0];
      end
      if (state == S_HDR && in_rx) busy_q <= 1'b1;
      if (state == S_HDR && byte_last) begin
        cnt <= word;
        k   <= '0;
      end
      // Words past DEPTH are still consumed so the stream stays aligned.
      if (state == S_DATA && byte_last) begin
        lw.we <= (k < 32'(DEPTH));
        lw.a  <= BASE_ADDR + k;
        lw.wd <= word;
        k     <= k + 32'd1;
        if (k >= 32'(DEPTH)) ovf_q <= 1'b1;
      end
      if (state_nxt == S_DONE) busy_q <= 1'b0;
      done_q <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    bus.mem_we = lw.we;
    bus.mem_a  = lw.a;
    bus.mem_wd = lw.wd;
    if (state == S_DONE) begin
      bus.mem_we = bus.cpu_we;
      bus.mem_a  = bus.cpu_a;
      bus.mem_wd = bus.cpu_wd;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule
